deserializer: RTL

Receive-side companion to `serializer`, placed directly downstream of it. It takes the narrow word stream the serializer emits (one `in_bit_width` word per strobe, no backpressure) and reassembles it into wide `out_bit_width` words. Each wide word is presented to the consumer through a valid/ready handshake. Words that cannot be stored are dropped and flagged; they are never silently overwritten.

---
 rtl/deserializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/deserializer.sv
// Reassembles a stream of narrow words into wide words delivered over valid/ready.
// Optional saturating drop counter on overflow_count when DESER_OVF_COUNT_EN is defined.
module deserializer #(
    parameter int unsigned in_bit_width  = 32,
    parameter int unsigned out_bit_width = 512
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              data_valid,
    input  logic [in_bit_width-1:0]                           data_in,
    input  logic                                              out_ready,
    output logic                                              out_valid,
    output logic [out_bit_width-1:0]                          data_out,
    output logic                                              overflow,
    output logic [$clog2(out_bit_width/in_bit_width)-1:0]     seg_count
`ifdef DESER_OVF_COUNT_EN
    ,
    output logic [15:0]                                       overflow_count
`endif
);

    localparam int unsigned num_segments = out_bit_width / in_bit_width;
    localparam int unsigned seg_w        = $clog2(num_segments);
    localparam int unsigned cnt_w        = 16;

    logic [out_bit_width-1:0] asm_q, asm_d;
    logic                     asm_full_q, asm_full_d;
    logic [out_bit_width-1:0] data_out_q, data_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overflow_q, overflow_d;
    logic [seg_w-1:0]         seg_count_q, seg_count_d;

    logic drain;
    logic accept;
    logic last_seg;
    logic out_free;

    // A full assembly register blocks new words unless it drains on this same edge.
    always_comb begin
        drain    = out_valid_q && out_ready;
        accept   = data_valid && (!asm_full_q || drain);
        last_seg = accept && (seg_count_q == seg_w'(num_segments - 1));
        out_free = !out_valid_q || drain;

        asm_d       = asm_q;
        asm_full_d  = asm_full_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;
        seg_count_d = seg_count_q;
        overflow_d  = data_valid && !accept;

        if (accept) begin
            for (int unsigned i = 0; i < num_segments; i++) begin
                if (seg_count_q == seg_w'(i)) begin
                    asm_d[i*in_bit_width +: in_bit_width] = data_in;
                end
            end
            seg_count_d = last_seg ? '0 : seg_count_q + seg_w'(1);
        end

        if (asm_full_q && drain) begin
            data_out_d  = asm_q;
            out_valid_d = 1'b1;
            asm_full_d  = 1'b0;
        end else if (last_seg && out_free) begin
            // Completed word bypasses asm, including the segment written this edge.
            data_out_d  = asm_d;
            out_valid_d = 1'b1;
        end else if (last_seg) begin
            asm_full_d  = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q       <= '0;
            asm_full_q  <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            seg_count_q <= '0;
        end else begin
            asm_q       <= asm_d;
            asm_full_q  <= asm_full_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            seg_count_q <= seg_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign overflow  = overflow_q;
    assign seg_count = seg_count_q;

`ifdef DESER_OVF_COUNT_EN
    logic [cnt_w-1:0] ovf_cnt_q, ovf_cnt_d;

    // Saturating count of dropped words.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (overflow_d && (ovf_cnt_q != {cnt_w{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + cnt_w'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign overflow_count = ovf_cnt_q;
`endif

endmodule
